// File: rtl/lfsr_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lfsr_pkg : shared constants and FSM encoding for the LFSR period meter
// Rev 1.0
// ---------------------------------------------------------------------------
package lfsr_pkg;

   localparam int LFSR_WIDTH         = 8;
   localparam int DEFAULT_CNT_W      = 10;
   localparam int DEFAULT_MAX_PERIOD = 1023;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARM   = 2'd1,
      S_COUNT = 2'd2,
      S_DONE  = 2'd3
   } state_e;

endpackage
`default_nettype wire

// File: rtl/lfsr_period_meter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lfsr_period_meter_if : command, sample stream and result bundle of the meter
// Rev 1.0
// ---------------------------------------------------------------------------
interface lfsr_period_meter_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 10
);
   logic             start;
   logic             sample_valid;
   logic [WIDTH-1:0] sample;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] ones;
   logic             stuck;
   logic             timeout;

   modport master (
      output start, sample_valid, sample,
      input  busy, done, period, ones, stuck, timeout
   );

   modport slave (
      input  start, sample_valid, sample,
      output busy, done, period, ones, stuck, timeout
   );
endinterface
`default_nettype wire

// File: rtl/lfsr_period_meter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lfsr_period_meter : measures the recurrence period and bit-0 ones count of
//                     an LFSR sample stream, flagging lockup and timeout
// Rev 1.0
// ---------------------------------------------------------------------------
module lfsr_period_meter
   import lfsr_pkg::*;
#(
   parameter int WIDTH      = LFSR_WIDTH,
   parameter int CNT_W      = DEFAULT_CNT_W,
   parameter int MAX_PERIOD = DEFAULT_MAX_PERIOD
) (
   input wire logic           clk,
   input wire logic           rst,
   lfsr_period_meter_if.slave meter
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);

   state_e           state_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] ref_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] ones_acc_q;
   logic [CNT_W-1:0] period_q;
   logic [CNT_W-1:0] ones_q;
   logic             stuck_q;
   logic             timeout_q;

   logic [CNT_W-1:0] cnt_inc;
   logic             sample_zero;
   logic             ref_match;
   logic             limit_hit;

   assign cnt_inc     = cnt_q + CNT_W'(1);
   assign sample_zero = (meter.sample == '0);
   assign ref_match   = (meter.sample == ref_q);
   assign limit_hit   = (cnt_inc == MAX_CNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (meter.start) begin
                  state_q <= S_ARM;
                  busy_q  <= 1'b1;
               end
            end
            S_ARM: begin
               if (meter.sample_valid) begin
                  if (sample_zero) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_COUNT;
                  end
               end
            end
            S_COUNT: begin
               if (meter.sample_valid && (ref_match || limit_hit)) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // The matching sample closes the window, so it is never added to ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         ref_q      <= '0;
         cnt_q      <= '0;
         ones_acc_q <= '0;
         period_q   <= '0;
         ones_q     <= '0;
         stuck_q    <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (meter.start) begin
                  stuck_q   <= 1'b0;
                  timeout_q <= 1'b0;
               end
            end
            S_ARM: begin
               if (meter.sample_valid) begin
                  ref_q      <= meter.sample;
                  cnt_q      <= '0;
                  ones_acc_q <= CNT_W'(meter.sample[0]);
                  if (sample_zero) begin
                     period_q <= CNT_W'(1);
                     ones_q   <= '0;
                     stuck_q  <= 1'b1;
                  end
               end
            end
            S_COUNT: begin
               if (meter.sample_valid) begin
                  if (ref_match) begin
                     period_q <= cnt_inc;
                     ones_q   <= ones_acc_q;
                  end else if (limit_hit) begin
                     period_q  <= '0;
                     ones_q    <= ones_acc_q;
                     timeout_q <= 1'b1;
                  end else begin
                     cnt_q      <= cnt_inc;
                     ones_acc_q <= ones_acc_q + CNT_W'(meter.sample[0]);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign meter.busy    = busy_q;
   assign meter.done    = done_q;
   assign meter.period  = period_q;
   assign meter.ones    = ones_q;
   assign meter.stuck   = stuck_q;
   assign meter.timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_period_meter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lfsr_period_meter : directed table and sequence bench for the period meter
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_lfsr_period_meter;
   import lfsr_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lfsr_period_meter_if #(.WIDTH(8), .CNT_W(10)) bus ();
   lfsr_period_meter_if #(.WIDTH(8), .CNT_W(10)) bus16 ();

   assign bus16.start        = bus.start;
   assign bus16.sample_valid = bus.sample_valid;
   assign bus16.sample       = bus.sample;

   lfsr_period_meter #(.WIDTH(8), .CNT_W(10), .MAX_PERIOD(1023)) dut (
      .clk   (clk),
      .rst   (rst),
      .meter (bus)
   );

   lfsr_period_meter #(.WIDTH(8), .CNT_W(10), .MAX_PERIOD(16)) dut16 (
      .clk   (clk),
      .rst   (rst),
      .meter (bus16)
   );

   typedef struct {
      string      name;
      logic       preval;
      logic       gap;
      int         n;
      logic [7:0] smp [0:7];
      int         period;
      int         ones;
      int         stuck;
      int         tmo;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Maximal-length feedback x^8+x^4+x^3+x^2+1
   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   task automatic pulse_start(input logic val);
      @(negedge clk);
      bus.start        = 1'b1;
      bus.sample_valid = val;
      bus.sample       = 8'h00;
      @(negedge clk);
      bus.start        = 1'b0;
      bus.sample_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int early;
      early = 0;
      pulse_start(v.preval);
      chk({v.name, "_busy_arm"}, int'(bus.busy), 1);
      for (int i = 0; i < v.n; i++) begin
         if (v.gap) begin
            bus.sample_valid = 1'b0;
            bus.sample       = 8'hA5;
            @(negedge clk);
            if (bus.done) early++;
         end
         bus.sample_valid = 1'b1;
         bus.sample       = v.smp[i];
         @(negedge clk);
         if (bus.done && i != v.n - 1) early++;
      end
      bus.sample_valid = 1'b0;
      chk({v.name, "_no_early_done"}, early, 0);
      chk({v.name, "_done"},    int'(bus.done),    1);
      chk({v.name, "_period"},  int'(bus.period),  v.period);
      chk({v.name, "_ones"},    int'(bus.ones),    v.ones);
      chk({v.name, "_stuck"},   int'(bus.stuck),   v.stuck);
      chk({v.name, "_timeout"}, int'(bus.timeout), v.tmo);
      chk({v.name, "_busy_end"}, int'(bus.busy),   0);
      @(negedge clk);
      chk({v.name, "_done_1cyc"}, int'(bus.done),   0);
      chk({v.name, "_hold"},      int'(bus.period), v.period);
   endtask

   // Feeds the LFSR stream until done or budget; returns samples consumed.
   task automatic lfsr_measure(inout logic [7:0] s, output int k, output int seen,
                               input int ignore_at);
      k    = 0;
      seen = 0;
      for (int i = 0; i < 600 && seen == 0; i++) begin
         bus.sample_valid = 1'b1;
         bus.sample       = s;
         bus.start        = (i == ignore_at);
         s = lfsr_next(s);
         @(negedge clk);
         k++;
         if (bus.done) seen = 1;
      end
      bus.sample_valid = 1'b0;
      bus.start        = 1'b0;
   endtask

   vec_t vecs [0:5];

   initial begin
      logic [7:0] s;
      int k, seen, ndone;

      vecs[0] = '{name:"seq",     preval:0, gap:0, n:6, smp:'{1,2,3,4,0,1,0,0},
                  period:5, ones:2, stuck:0, tmo:0};
      vecs[1] = '{name:"seq_gap", preval:0, gap:1, n:6, smp:'{1,2,3,4,0,1,0,0},
                  period:5, ones:2, stuck:0, tmo:0};
      vecs[2] = '{name:"stuck",   preval:0, gap:0, n:1, smp:'{0,0,0,0,0,0,0,0},
                  period:1, ones:0, stuck:1, tmo:0};
      vecs[3] = '{name:"seq_b",   preval:0, gap:0, n:4, smp:'{5,7,9,5,0,0,0,0},
                  period:3, ones:3, stuck:0, tmo:0};
      vecs[4] = '{name:"self",    preval:0, gap:0, n:2, smp:'{8'h81,8'h81,0,0,0,0,0,0},
                  period:1, ones:1, stuck:0, tmo:0};
      vecs[5] = '{name:"st_val",  preval:1, gap:0, n:3, smp:'{3,6,3,0,0,0,0,0},
                  period:2, ones:1, stuck:0, tmo:0};

      rst = 1'b1;
      bus.start        = 1'b0;
      bus.sample_valid = 1'b0;
      bus.sample       = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_busy",    int'(bus.busy),    0);
      chk("rst_done",    int'(bus.done),    0);
      chk("rst_period",  int'(bus.period),  0);
      chk("rst_ones",    int'(bus.ones),    0);
      chk("rst_stuck",   int'(bus.stuck),   0);
      chk("rst_timeout", int'(bus.timeout), 0);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      chk("rst_start_busy", int'(bus.busy), 0);
      rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 6; v++) run_vec(vecs[v]);

      // Timeout on the MAX_PERIOD=16 instance with a 5-bit up-counter
      pulse_start(1'b0);
      k = 0;
      seen = 0;
      for (int i = 1; i <= 40 && seen == 0; i++) begin
         bus.sample_valid = 1'b1;
         bus.sample       = 8'(i & 31);
         @(negedge clk);
         k = i;
         if (bus16.done) seen = 1;
      end
      bus.sample_valid = 1'b0;
      chk("tmo_seen",    seen, 1);
      chk("tmo_samples", k, 17);
      chk("tmo_period",  int'(bus16.period),  0);
      chk("tmo_ones",    int'(bus16.ones),    8);
      chk("tmo_flag",    int'(bus16.timeout), 1);
      chk("tmo_stuck",   int'(bus16.stuck),   0);

      // The big instance is still counting: this start must be ignored there
      pulse_start(1'b0);
      chk("busy_start_ignored", int'(bus.busy), 1);
      chk("tmo_cleared",        int'(bus16.timeout), 0);

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_busy", int'(bus.busy), 0);
      chk("rst_mid_done", int'(bus.done), 0);

      s = 8'h01;
      pulse_start(1'b0);
      lfsr_measure(s, k, seen, 50);
      chk("lfsr_seen",    seen, 1);
      chk("lfsr_samples", k, 256);
      chk("lfsr_period",  int'(bus.period), 255);
      chk("lfsr_ones",    int'(bus.ones),   128);

      // Abort a second measurement with rst, then let the stream run idle
      pulse_start(1'b0);
      ndone = 0;
      for (int i = 0; i < 400; i++) begin
         bus.sample_valid = 1'b1;
         bus.sample       = s;
         rst = (i == 100);
         s = lfsr_next(s);
         @(negedge clk);
         if (bus.done) ndone++;
      end
      rst = 1'b0;
      bus.sample_valid = 1'b0;
      chk("abort_no_done", ndone, 0);
      chk("abort_idle",    int'(bus.busy), 0);

      pulse_start(1'b0);
      lfsr_measure(s, k, seen, -1);
      chk("relfsr_seen",   seen, 1);
      chk("relfsr_period", int'(bus.period), 255);
      chk("relfsr_ones",   int'(bus.ones),   128);
      @(negedge clk);
      chk("relfsr_done_1cyc", int'(bus.done), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
